game_tick_scheduler: RTL
========================

# game_tick_scheduler

Central timing and sequencing controller for the Pac-Man design. It produces single-cycle enable strobes for the pixel pipeline (25 MHz), the display scan (400 Hz) and the game tick (2–16 Hz, speed-selectable), instead of divided clocks. On each game tick it runs the update units in a fixed order: Pac-Man move, ghost move, collision check. Each phase uses a go/done handshake with a timeout.

## Interface
- PIX_DIV, 4: clk cycles per pix_en strobe
- SCAN_CYCLES, 250000: clk cycles per scan_en strobe (400 Hz at 100 MHz)
- BASE_TICK_CYCLES, 50000000: game tick period at speed 0 (2 Hz)
- TIMEOUT_CYCLES, 1024: max wait for any phase done
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous, active-high reset
- speed  in  2  tick period = BASE_TICK_CYCLES >> speed
- pause  in  1  freezes game tick counter
- pac_done, ghost_done, coll_done  in  1 each  phase completion pulses
- pix_en, scan_en, tick_en  out  1 each  single-cycle strobes
- pac_go, ghost_go, coll_go  out  1 each  single-cycle phase start strobes
- frame_done  out  1  single-cycle, end of update sequence
- busy  out  1  sequence in progress (state != IDLE)
- timeout_err  out  1  sticky, set on any phase timeout
- overrun_cnt  out  8  saturating count of dropped ticks

## Operation
- Reset: all counters 0, state IDLE, every output 0. The speed latch loads the value of speed present during reset.
- pix_en and scan_en are free-running. Each counter counts 0..N-1 and pulses when it equals N-1. They ignore pause and the state machine.
- Tick counter: counts 0..(period-1) and pulses tick_en at period-1, then wraps.
  - speed is latched only at wrap. A change mid-period takes effect on the next period.
  - While pause=1 the counter holds and tick_en stays 0. Counting resumes from the held value.
- State machine: IDLE -> PAC_GO -> PAC_WAIT -> GHOST_GO -> GHOST_WAIT -> COLL_GO -> COLL_WAIT -> DONE -> IDLE.
  - A *_GO state lasts one cycle and asserts the matching go.
  - A *_WAIT state exits on the matching done, or when the timeout counter reaches TIMEOUT_CYCLES-1. A timeout sets timeout_err.
  - DONE lasts one cycle and asserts frame_done.
- IDLE leaves only on tick_en. A tick_en in any other state is dropped and increments overrun_cnt, which saturates at 255.
- done inputs are sampled only in their own WAIT state. A done in the same cycle as its go, or in any other state, is ignored.
- pause asserted mid-sequence does not stall the sequence. The in-flight sequence completes.
- The timeout counter clears on entry to every WAIT state.
- Width rule: period shift is a logical right shift of a 26-bit constant. Comparison is equality against period-1.

## Timing
- First pix_en at cycle PIX_DIV-1 after rst deasserts (cycle 0 is the first cycle with rst low).
- First scan_en at cycle SCAN_CYCLES-1.
- First tick_en at cycle period-1.
- tick_en at cycle N gives:
  - pac_go at N+1,
  - PAC_WAIT from N+2.
- pac_done at M gives ghost_go at M+1.
- coll_done at K gives:
  - frame_done at K+1,
  - IDLE at K+2.
- busy is high from N+1 through K+1.
- Minimum sequence length: 7 cycles (done on the first WAIT cycle of each phase).
- Timeout with no done: WAIT lasts exactly TIMEOUT_CYCLES cycles, then the next GO follows.
- rst mid-sequence: next cycle is IDLE, all go/strobe outputs 0, timeout_err and overrun_cnt cleared.

## Structure
- Package game_timing_pkg holds:
  - state enum sched_state_t,
  - default period constants (PIX_DIV, SCAN_CYCLES, BASE_TICK_CYCLES, TIMEOUT_CYCLES),
  - OVERRUN_MAX = 255.
- Sub-module rate_enable_gen holds one counter with period input, hold input and pulse output. It is instantiated for pix, scan and tick; pix and scan have hold tied to 0.
- The sequencer FSM, timeout counter and overrun counter live in the top module.

## Test plan
The bench overrides PIX_DIV=4, SCAN_CYCLES=10, BASE_TICK_CYCLES=64, TIMEOUT_CYCLES=16.

- Reset released, speed=0, pause=0 -> pix_en at cycles 3, 7, 11…; scan_en at 9, 19…; tick_en at 63, 127.
- tick_en at 63 with each done returned 2 cycles after its go -> pac_go at 64, ghost_go at 67, coll_go at 70, frame_done at 73, busy low at 74.
- ghost_done never returned -> GHOST_WAIT lasts 16 cycles, then coll_go; timeout_err=1 and stays 1 until rst.
- done held off 100 cycles past each tick (timeout forced) at speed=3 (period 8) -> overrun_cnt increments on each dropped tick and saturates at 255.
- speed changed 0->2 at cycle 30 -> next tick_en still at 63, following one at 79; pause high at cycles 70–89 delays that tick to 99.
- rst pulsed during COLL_WAIT -> next cycle busy=0, all outputs 0, overrun_cnt=0; pac_done arriving in IDLE ignored.

Source files
------------

// File: rtl/game_timing_pkg.sv
// Shared timing constants and sequencer state type for the game tick scheduler.
package game_timing_pkg;

  localparam int unsigned CNT_W            = 26;
  localparam int unsigned PIX_DIV          = 4;
  localparam int unsigned SCAN_CYCLES      = 250_000;
  localparam int unsigned BASE_TICK_CYCLES = 50_000_000;
  localparam int unsigned TIMEOUT_CYCLES   = 1024;
  localparam int unsigned OVERRUN_MAX      = 255;

  typedef enum logic [2:0] {
    StIdle,
    StPacGo,
    StPacWait,
    StGhostGo,
    StGhostWait,
    StCollGo,
    StCollWait,
    StDone
  } sched_state_t;

  // Game tick period for a given speed setting: logical right shift of the base period.
  function automatic logic [CNT_W-1:0] tick_period_of(input int unsigned base,
                                                      input logic [1:0] speed);
    logic [CNT_W-1:0] base_w;
    base_w = CNT_W'(base);
    return base_w >> speed;
  endfunction

endpackage

// File: rtl/rate_enable_gen.sv
// Free-running modulo counter producing a one-cycle enable strobe every `period` cycles.
module rate_enable_gen
  import game_timing_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] period,
  input  logic             hold,
  output logic             pulse
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == period - 1'b1);

  always_comb begin
    cnt_d = cnt_q;
    if (!hold) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse = at_last & ~hold;

endmodule

// File: rtl/game_tick_scheduler.sv
// Generates pixel/scan/game-tick enables and sequences the per-tick update phases
// (Pac-Man, ghosts, collision) through go/done handshakes with a timeout.
module game_tick_scheduler #(
  parameter int unsigned PIX_DIV          = game_timing_pkg::PIX_DIV,
  parameter int unsigned SCAN_CYCLES      = game_timing_pkg::SCAN_CYCLES,
  parameter int unsigned BASE_TICK_CYCLES = game_timing_pkg::BASE_TICK_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES   = game_timing_pkg::TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       pac_done,
  input  logic       ghost_done,
  input  logic       coll_done,
  output logic       pix_en,
  output logic       scan_en,
  output logic       tick_en,
  output logic       pac_go,
  output logic       ghost_go,
  output logic       coll_go,
  output logic       frame_done,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] overrun_cnt
);

  import game_timing_pkg::*;

  localparam int unsigned      TMO_W       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       OVR_MAX     = 8'(OVERRUN_MAX);
  localparam logic [CNT_W-1:0] PIX_PERIOD  = CNT_W'(PIX_DIV);
  localparam logic [CNT_W-1:0] SCAN_PERIOD = CNT_W'(SCAN_CYCLES);

  sched_state_t     state_q;
  logic [1:0]       speed_q;
  logic [CNT_W-1:0] tick_period;
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_last;
  logic [7:0]       overrun_q;
  logic             timeout_err_q;
  logic             pac_go_q;
  logic             ghost_go_q;
  logic             coll_go_q;
  logic             frame_done_q;
  logic             busy_q;

  assign tick_period = tick_period_of(BASE_TICK_CYCLES, speed_q);
  assign tmo_last    = (tmo_q == TMO_LAST);

  rate_enable_gen u_pix (
    .clk    (clk),
    .rst    (rst),
    .period (PIX_PERIOD),
    .hold   (1'b0),
    .pulse  (pix_en)
  );

  rate_enable_gen u_scan (
    .clk    (clk),
    .rst    (rst),
    .period (SCAN_PERIOD),
    .hold   (1'b0),
    .pulse  (scan_en)
  );

  rate_enable_gen u_tick (
    .clk    (clk),
    .rst    (rst),
    .period (tick_period),
    .hold   (pause),
    .pulse  (tick_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      speed_q       <= speed;
      tmo_q         <= '0;
      overrun_q     <= '0;
      timeout_err_q <= 1'b0;
      pac_go_q      <= 1'b0;
      ghost_go_q    <= 1'b0;
      coll_go_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      pac_go_q     <= 1'b0;
      ghost_go_q   <= 1'b0;
      coll_go_q    <= 1'b0;
      frame_done_q <= 1'b0;

      // tick_en only fires on wrap, so a new speed applies from the next period.
      if (tick_en) begin
        speed_q <= speed;
      end
      if (tick_en && (state_q != StIdle) && (overrun_q != OVR_MAX)) begin
        overrun_q <= overrun_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (tick_en) begin
            state_q  <= StPacGo;
            pac_go_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        StPacGo: begin
          state_q <= StPacWait;
          tmo_q   <= '0;
        end
        StPacWait: begin
          if (pac_done || tmo_last) begin
            state_q    <= StGhostGo;
            ghost_go_q <= 1'b1;
            if (!pac_done) timeout_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StGhostGo: begin
          state_q <= StGhostWait;
          tmo_q   <= '0;
        end
        StGhostWait: begin
          if (ghost_done || tmo_last) begin
            state_q   <= StCollGo;
            coll_go_q <= 1'b1;
            if (!ghost_done) timeout_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StCollGo: begin
          state_q <= StCollWait;
          tmo_q   <= '0;
        end
        StCollWait: begin
          if (coll_done || tmo_last) begin
            state_q      <= StDone;
            frame_done_q <= 1'b1;
            if (!coll_done) timeout_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pac_go      = pac_go_q;
  assign ghost_go    = ghost_go_q;
  assign coll_go     = coll_go_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign overrun_cnt = overrun_q;

endmodule
